// File: rtl/watch_ram.sv
// Single-port data RAM with hardware clear after reset and watched result cells.
// All state updates on the falling edge of clk; reads are combinational.
module watch_ram #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DEPTH          = 4096,
  parameter int unsigned NUM_WATCH      = 2,
  parameter int unsigned WATCH_BASE     = 257,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            WE,
  input  logic [ADDR_WIDTH-1:0]           Address,
  input  logic [DATA_WIDTH-1:0]           WriteDataBus,
  output logic [DATA_WIDTH-1:0]           ReadDataBus,
  output logic                            Busy,
  output logic [NUM_WATCH*DATA_WIDTH-1:0] WatchData,
  output logic [NUM_WATCH-1:0]            WatchValid,
  input  logic [NUM_WATCH-1:0]            WatchAck,
  output logic [NUM_WATCH-1:0]            WatchOverrun
);

  localparam int unsigned          IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]  DepthW   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {StClear, StRun} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   clear_addr_q;
  logic                    busy_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    run;
  logic                    in_range;
  logic                    mem_we;
  logic [IdxW-1:0]         mem_idx;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [NUM_WATCH-1:0]    hit;

  logic [NUM_WATCH-1:0][DATA_WIDTH-1:0] wdata_q;
  logic [NUM_WATCH-1:0]                 valid_q;
  logic [NUM_WATCH-1:0]                 ovr_q;

  assign run      = (state_q == StRun);
  assign in_range = ({1'b0, Address} < DepthW);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR_ON_RESET ? StClear : StRun;
      clear_addr_q <= '0;
      busy_q       <= CLEAR_ON_RESET;
    end else if (state_q == StClear) begin
      clear_addr_q <= clear_addr_q + 1'b1;
      if (clear_addr_q == LastAddr) begin
        state_q <= StRun;
        busy_q  <= 1'b0;
      end
    end
  end

  // Single write port shared between the clear sequencer and the CPU.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = Address[IdxW-1:0];
    mem_wdata = WriteDataBus;
    if (!run) begin
      mem_we    = 1'b1;
      mem_idx   = clear_addr_q[IdxW-1:0];
      mem_wdata = '0;
    end else if (WE && in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  always_comb begin
    ReadDataBus = '0;
    if (run && in_range) begin
      ReadDataBus = mem[Address[IdxW-1:0]];
    end
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(NUM_WATCH); i++) begin
      hit[i] = run && WE && (Address == ADDR_WIDTH'(WATCH_BASE + i));
    end
  end

  // A watched write always wins over a concurrent ack; the ack only clears overrun.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q <= '0;
      valid_q <= '0;
      ovr_q   <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_WATCH); i++) begin
        if (hit[i]) begin
          wdata_q[i] <= WriteDataBus;
          valid_q[i] <= 1'b1;
          if (WatchAck[i]) begin
            ovr_q[i] <= 1'b0;
          end else if (valid_q[i]) begin
            ovr_q[i] <= 1'b1;
          end
        end else if (run && WatchAck[i]) begin
          valid_q[i] <= 1'b0;
          ovr_q[i]   <= 1'b0;
        end
      end
    end
  end

  assign Busy         = busy_q;
  assign WatchData    = wdata_q;
  assign WatchValid   = valid_q;
  assign WatchOverrun = ovr_q;

endmodule

// File: tb/tb_watch_ram.sv
// Randomised self-checking bench for watch_ram against a behavioural model of
// the memory array and the watch handshake.
module tb_watch_ram;

  localparam int unsigned Depth = 4096;
  localparam int unsigned Base  = 257;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        WE;
  logic [15:0] Address;
  logic [7:0]  WriteDataBus;
  logic [7:0]  ReadDataBus;
  logic        Busy;
  logic [15:0] WatchData;
  logic [1:0]  WatchValid;
  logic [1:0]  WatchAck;
  logic [1:0]  WatchOverrun;

  watch_ram dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .WE           (WE),
    .Address      (Address),
    .WriteDataBus (WriteDataBus),
    .ReadDataBus  (ReadDataBus),
    .Busy         (Busy),
    .WatchData    (WatchData),
    .WatchValid   (WatchValid),
    .WatchAck     (WatchAck),
    .WatchOverrun (WatchOverrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [Depth];
  logic [7:0] ref_wd  [2];
  logic [1:0] ref_v;
  logic [1:0] ref_o;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_read(input int unsigned a);
    return (a < Depth) ? ref_mem[a] : 8'h00;
  endfunction

  // Memory cleared and watch state zero after a completed clear sequence.
  task automatic model_reset();
    for (int a = 0; a < int'(Depth); a++) ref_mem[a] = 8'h00;
    ref_wd[0] = 8'h00;
    ref_wd[1] = 8'h00;
    ref_v = 2'b00;
    ref_o = 2'b00;
  endtask

  task automatic model_edge(input logic we, input int unsigned addr, input logic [7:0] data,
                            input logic [1:0] ack);
    for (int i = 0; i < 2; i++) begin
      if (we && addr == Base + i) begin
        ref_wd[i] = data;
        if (ack[i]) ref_o[i] = 1'b0;
        else if (ref_v[i]) ref_o[i] = 1'b1;
        ref_v[i] = 1'b1;
      end else if (ack[i]) begin
        ref_v[i] = 1'b0;
        ref_o[i] = 1'b0;
      end
    end
    if (we && addr < Depth) ref_mem[addr] = data;
  endtask

  task automatic drive(input logic we, input int unsigned addr, input logic [7:0] data,
                       input logic [1:0] ack);
    WE           = we;
    Address      = addr[15:0];
    WriteDataBus = data;
    WatchAck     = ack;
  endtask

  task automatic step();
    @(negedge clk);
    model_edge(WE, Address, WriteDataBus, WatchAck);
    #1;
  endtask

  task automatic cyc(input logic we, input int unsigned addr, input logic [7:0] data,
                     input logic [1:0] ack);
    drive(we, addr, data, ack);
    step();
  endtask

  task automatic rd_check(input string tag, input int unsigned addr, input logic [7:0] exp);
    WE      = 1'b0;
    Address = addr[15:0];
    #1;
    check_eq(tag, ReadDataBus, exp);
  endtask

  task automatic check_watch(input string tag);
    check_eq({tag, "_valid"}, WatchValid, ref_v);
    check_eq({tag, "_ovr"}, WatchOverrun, ref_o);
    check_eq({tag, "_data"}, WatchData, {ref_wd[1], ref_wd[0]});
  endtask

  // Counts falling edges with Busy high while hammering writes that must be ignored.
  task automatic wait_clear(input string tag);
    int n = 0;
    drive(1'b1, Base, 8'h5A, 2'b11);
    while (Busy && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
      if (n == 10) check_eq({tag, "_rd_busy"}, ReadDataBus, 8'h00);
    end
    check_eq({tag, "_busy_edges"}, n, Depth);
    drive(1'b0, 0, 8'h00, 2'b00);
    model_reset();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid", WatchValid, 2'b00);
    check_eq("rst_busy", Busy, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned sel, addr;
    logic we;
    logic [1:0] ack;
    logic [7:0] data;

    rst_n = 1'b0;
    drive(1'b0, 0, 8'h00, 2'b00);
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_busy", Busy, 1'b1);
    check_eq("reset_valid", WatchValid, 2'b00);
    check_eq("reset_ovr", WatchOverrun, 2'b00);
    check_eq("reset_data", WatchData, 16'h0000);
    rst_n = 1'b1;
    wait_clear("clear1");
    check_watch("after_clear1");
    rd_check("clear1_rd257", 257, 8'h00);

    // Fill with 0xA5, then reset mid-run and confirm the clear wipes it.
    for (int a = 0; a < int'(Depth); a++) cyc(1'b1, a, 8'hA5, 2'b00);
    rd_check("fill_rd257", 257, 8'hA5);
    check_watch("fill");
    pulse_reset();
    wait_clear("clear2");
    rd_check("clear2_rd0", 0, 8'h00);
    rd_check("clear2_rd257", 257, 8'h00);
    rd_check("clear2_rd4095", 4095, 8'h00);
    check_watch("after_clear2");

    cyc(1'b1, 100, 8'h3C, 2'b00);
    cyc(1'b1, 4095, 8'h7E, 2'b00);
    cyc(1'b1, 5000, 8'hFF, 2'b00);
    rd_check("ram_rd100", 100, 8'h3C);
    rd_check("ram_rd4095", 4095, 8'h7E);
    rd_check("ram_rd5000", 5000, 8'h00);
    rd_check("ram_rd904_alias", 904, 8'h00);
    rd_check("ram_rd99", 99, 8'h00);

    cyc(1'b1, 257, 8'h0D, 2'b00);
    check_eq("watch0_data", WatchData[7:0], 8'h0D);
    check_eq("watch0_valid", WatchValid, 2'b01);
    rd_check("watch0_mem", 257, 8'h0D);
    cyc(1'b0, 0, 8'h00, 2'b01);
    check_eq("watch0_ack", WatchValid, 2'b00);

    cyc(1'b1, 258, 8'h01, 2'b00);
    cyc(1'b1, 258, 8'h02, 2'b00);
    check_eq("ovr_data", WatchData[15:8], 8'h02);
    check_eq("ovr_flag", WatchOverrun, 2'b10);
    check_eq("ovr_valid", WatchValid, 2'b10);
    cyc(1'b0, 0, 8'h00, 2'b10);
    check_eq("ovr_ack_valid", WatchValid, 2'b00);
    check_eq("ovr_ack_flag", WatchOverrun, 2'b00);

    cyc(1'b1, 257, 8'h11, 2'b00);
    cyc(1'b1, 257, 8'h22, 2'b01);
    check_eq("simul_valid", WatchValid[0], 1'b1);
    check_eq("simul_data", WatchData[7:0], 8'h22);
    check_eq("simul_ovr", WatchOverrun[0], 1'b0);
    check_watch("directed_end");

    // Reset in the middle of a clear restarts the full sequence.
    pulse_reset();
    drive(1'b1, 100, 8'h99, 2'b00);
    repeat (1000) @(negedge clk);
    #1;
    check_eq("midclear_busy", Busy, 1'b1);
    pulse_reset();
    wait_clear("clear3");
    rd_check("clear3_rd100", 100, 8'h00);
    check_watch("after_clear3");

    for (int it = 0; it < 2000; it++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: addr = Base;
        3, 4:    addr = Base + 1;
        5, 6, 7: addr = $urandom_range(0, Depth - 1);
        8:       addr = $urandom_range(Depth, 65535);
        default: addr = ($urandom_range(0, 1) == 0) ? Base - 1 : Base + 2;
      endcase
      we   = ($urandom_range(0, 2) != 0);
      data = 8'($urandom);
      ack  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      drive(we, addr, data, ack);
      #1;
      check_eq("rand_rd_pre", ReadDataBus, ref_read(addr));
      step();
      check_eq("rand_rd_post", ReadDataBus, ref_read(addr));
      check_watch("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/watch_ram.md
# watch_ram

Parametrised single-port data RAM for the CPU data bus with hardware clear-on-reset and NUM_WATCH watched result cells. Each watched cell mirrors the last value the CPU wrote to a fixed address into a dedicated output register with a valid/acknowledge handshake and overrun detection. It sits on the CPU data bus and drives result displays and I/O without polling.

## Interface
- DATA_WIDTH, 8: data bus width in bits.
- ADDR_WIDTH, 16: address bus width in bits.
- DEPTH, 4096: number of words; must satisfy DEPTH <= 2^ADDR_WIDTH.
- NUM_WATCH, 2: number of watch channels, 1..8.
- WATCH_BASE, 257: channel i watches address WATCH_BASE+i; WATCH_BASE+NUM_WATCH-1 < DEPTH.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset; 0 = array contents untouched by reset.

- clk  in  1  system clock; all state updates on the falling edge.
- rst_n  in  1  asynchronous, active-low reset.
- WE  in  1  write enable, sampled on the falling edge.
- Address  in  ADDR_WIDTH  word address.
- WriteDataBus  in  DATA_WIDTH  write data.
- ReadDataBus  out  DATA_WIDTH  combinational read data.
- Busy  out  1  high while the clear sequence runs.
- WatchData  out  NUM_WATCH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- WatchValid  out  NUM_WATCH  per-channel new-data flag.
- WatchAck  in  NUM_WATCH  per-channel acknowledge, sampled on the falling edge.
- WatchOverrun  out  NUM_WATCH  per-channel sticky overrun flag.

## Operation
- FSM states: CLEAR, RUN.
- rst_n low forces:
  - state = CLEAR if CLEAR_ON_RESET, else RUN.
  - ClearAddr = 0.
  - Busy = CLEAR_ON_RESET.
  - WatchData = 0, WatchValid = 0, WatchOverrun = 0.
- CLEAR:
  - Each falling edge writes 0 to Memory[ClearAddr], then ClearAddr++.
  - The edge that writes DEPTH-1 moves the FSM to RUN and drops Busy.
  - WE, WatchAck and Address are ignored, and ReadDataBus = 0.
- RUN writes: WE=1 and Address < DEPTH gives Memory[Address] <= WriteDataBus on the falling edge.
- Out of range: Address >= DEPTH ignores writes and makes ReadDataBus = 0.
- Reads: ReadDataBus = Memory[Address] combinationally. Read-during-write returns the old word until the falling edge, then the new one.
- Watch channel i, on an edge in RUN with WE=1 and Address == WATCH_BASE+i:
  - WatchData[i] <= WriteDataBus; the memory cell is written as well.
  - WatchValid[i] <= 1.
  - If WatchValid[i] was already 1 and WatchAck[i]=0 on that edge, WatchOverrun[i] <= 1.
- WatchAck[i]=1 with no watched write on that edge: WatchValid[i] <= 0 and WatchOverrun[i] <= 0.
- Simultaneous watched write and ack on the same edge: the write wins. WatchValid[i] stays 1, WatchData updates, overrun is cleared and not set.
- Ack while WatchValid[i]=0 is a no-op.
- Writes to unwatched addresses never touch watch state.
- rst_n asserted mid-clear or mid-run aborts immediately and restarts the clear from address 0 after release.

## Timing
- Reset exit: with CLEAR_ON_RESET=1, Busy stays high for exactly DEPTH falling edges after rst_n rises. The first RUN write is accepted on edge DEPTH+1.
- Write latency: Memory, WatchData and WatchValid update on the same falling edge that samples WE.
- ReadDataBus is a zero-latency combinational path from Address and the memory array.
- WatchValid rises on the write edge and falls on the first ack edge that has no concurrent watched write.
- All outputs are glitch-free registered values except ReadDataBus.

## Test plan
- Reset clear: fill memory with 0xA5, pulse rst_n low, count Busy edges, then read addresses 0, 257 and 4095 -> Busy high for 4096 falling edges, all reads 0x00.
- Basic RAM: write 0x3C to address 100 and 0x7E to address 4095, read both back; write 0xFF to address 5000 -> reads 0x3C and 0x7E, address 5000 reads 0x00, no other cell changes.
- Watch handshake: write 0x0D to 257 -> WatchData[0]=0x0D, WatchValid=2'b01, memory[257]=0x0D; pulse WatchAck[0] -> WatchValid=2'b00.
- Overrun: write 0x01 then 0x02 to 258 with no ack -> WatchData[1]=0x02, WatchOverrun=2'b10; ack -> both flags clear.
- Simultaneous write and ack on 257 with value 0x22 -> WatchValid[0] stays 1, WatchData[0]=0x22, WatchOverrun[0]=0.
- Reset mid-clear: deassert rst_n, wait 1000 edges, reassert rst_n, release -> Busy lasts a full 4096 edges from the second release, and WE during Busy has no effect.
